pla_bist_sweeper: RTL
=====================

Name: pla_bist_sweeper

Overview:
- Sequential driver/reader for any combinational PLA block in the library (8 inputs x0..x7, 8 outputs z0..z7).
- Sweeps every input vector into the PLA under test, reads back its outputs and compacts them into an 8-bit MISR signature.
- Raises pass/fail against a known-good signature.
- Optionally streams each (vector, response) pair to an observer over a valid/ready port.
- Sits between the test controller and one PLA instance.

Parameters:
- N_IN, 8, PLA input width; sweep length is 2**N_IN vectors.
- N_OUT, 8, PLA output width; equals MISR width.
- SETTLE_CYCLES, 1, wait cycles after x changes before z is sampled (0..15).
- MISR_POLY, 8'hB8, Galois feedback taps.
- MISR_SEED, 8'hFF, signature reset/start value; must be nonzero.
- EXPECTED_SIG, 8'h00, golden signature compared at end of sweep.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a sweep.
- abort  in  1  synchronous cancel; returns to IDLE.
- x  out  N_IN  vector driven to the PLA inputs; bit 0 maps to x0.
- z  in  N_OUT  PLA outputs; bit 0 maps to z0.
- obs_valid  out  1  a captured pair is presented.
- obs_ready  in  1  observer accepts the pair.
- obs_vec  out  N_IN  vector of the presented pair.
- obs_resp  out  N_OUT  z captured for obs_vec.
- busy  out  1  high in SETTLE, SAMPLE and HOLD.
- done  out  1  high in DONE.
- pass  out  1  valid when done is high: signature == EXPECTED_SIG.
- signature  out  N_OUT  current MISR value.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; x=0; obs_valid=0; obs_vec=0; obs_resp=0; busy=0; done=0; pass=0; signature=MISR_SEED.
- x is registered directly from the vector counter and never changes mid-vector.
- IDLE:
  - start=1 -> SETTLE with vec=0, signature=MISR_SEED, settle counter=SETTLE_CYCLES.
  - If SETTLE_CYCLES=0, go straight to SAMPLE.
- SETTLE: decrement the counter each cycle; at 0 -> SAMPLE. x is held.
- SAMPLE (one cycle):
  - Capture z into obs_resp and vec into obs_vec; assert obs_valid from the next cycle.
  - Update the MISR: sig_next = {sig[6:0],1'b0} ^ (sig[7] ? MISR_POLY : 0) ^ z.
  - Next state is HOLD.
- HOLD: wait until obs_valid && obs_ready (obs_valid drops the cycle after the handshake). Then:
  - If vec == 2**N_IN-1 -> DONE.
  - Otherwise vec+1 -> SETTLE, or SAMPLE if SETTLE_CYCLES=0.
- Backpressure: obs_ready=0 stalls in HOLD indefinitely. x, obs_*, and signature stay stable. obs_valid must not drop before the handshake.
- Per-vector cost with obs_ready tied 1: SETTLE_CYCLES + 2 cycles (SETTLE, SAMPLE, HOLD).
- DONE:
  - done=1; pass=(signature==EXPECTED_SIG), registered on entry; busy=0; x holds the last vector.
  - start=1 -> new sweep as from IDLE. done and pass clear in that same transition.
- start while busy is ignored.
- abort=1 in any state: -> IDLE next cycle; x=0, obs_valid=0, signature=MISR_SEED, done=0, pass=0. abort has priority over start in the same cycle.
- The vector counter is N_IN+1 bits wide to avoid wrap ambiguity. Only the low N_IN bits drive x.
- Only rst_n is asynchronous. Every other input is synchronous to clk.

Decomposition:
- Package pla_bist_pkg holds:
  - state enum {IDLE, SETTLE, SAMPLE, HOLD, DONE};
  - default MISR_POLY/MISR_SEED constants;
  - a pure function misr_step(sig, z, poly), shared with the bench model.
- One sub-module, pla_misr: an N_OUT-wide register with load_seed and enable inputs. The FSM, counters and handshake live in pla_bist_sweeper.

Test Plan:
- Reset and start:
  - Stimulus: assert rst_n=0 mid-SETTLE, release, then pulse start.
  - Required: all outputs equal reset values while in reset; x=0; busy=1 one cycle after start; first SAMPLE at cycle 1+SETTLE_CYCLES.
- Full sweep with an identity PLA stub (z=x), SETTLE_CYCLES=1, obs_ready=1:
  - obs_vec runs 0..255 in order with obs_resp==obs_vec.
  - done rises after 768 cycles of busy.
  - signature equals the misr_step model fold over 0..255; pass=1 when EXPECTED_SIG is set to the model value and pass=0 for model^8'h01.
- Backpressure:
  - Stimulus: hold obs_ready=0 for 10 cycles at vec=8'h7F.
  - Required: x=8'h7F, obs_valid=1, and signature stable for all 10 cycles; sweep resumes at 8'h80 after the handshake; final signature is unchanged versus the no-stall run.
- Abort:
  - Stimulus: abort=1 together with start=1 at vec=8'h40.
  - Required: IDLE next cycle, x=0, signature=8'hFF, done=0; a later start sweeps from 0.
- SETTLE_CYCLES=0 with a constant-zero stub and start while busy:
  - Per-vector period is 2 cycles.
  - The ignored start does not restart the sweep.
  - The final signature matches the model with z=0.
- Restart from DONE:
  - Stimulus: start=1 in DONE.
  - Required: done and pass clear in that transition; the second sweep yields the identical signature.

Source files
------------

// File: rtl/pla_bist_pkg.sv
// ============================================================================
// Module  : pla_bist_pkg
// Purpose : Shared types, default constants and MISR step for the PLA sweeper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pla_bist_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETTLE = 3'd1,
        SAMPLE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [7:0] c_default_poly = 8'hB8;
    localparam logic [7:0] c_default_seed = 8'hFF;

    // Galois MISR step for any width up to 32; bits above width are masked off.
    function automatic logic [31:0] misr_step(
        input logic [31:0] sig,
        input logic [31:0] z,
        input logic [31:0] poly,
        input int unsigned width
    );
        logic [31:0] mask;
        logic [31:0] nxt;
        logic        msb;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        msb  = |(sig & (32'd1 << (width - 1)));
        nxt  = (sig << 1) ^ (msb ? poly : 32'd0) ^ z;
        return nxt & mask;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pla_misr.sv
// ============================================================================
// Module  : pla_misr
// Purpose : N_OUT-wide multiple-input signature register with seed load.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pla_misr
    import pla_bist_pkg::*;
#(
    parameter int unsigned          N_OUT     = 8,
    parameter logic [N_OUT-1:0]     MISR_POLY = c_default_poly,
    parameter logic [N_OUT-1:0]     MISR_SEED = c_default_seed
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_seed,
    input  logic             enable,
    input  logic [N_OUT-1:0] z,
    output logic [N_OUT-1:0] sig
);

    logic [N_OUT-1:0] r_sig;

    // Seed load wins over compaction so an abort during SAMPLE leaves the seed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= MISR_SEED;
        end else if (load_seed) begin
            r_sig <= MISR_SEED;
        end else if (enable) begin
            r_sig <= N_OUT'(misr_step(32'(r_sig), 32'(z), 32'(MISR_POLY), N_OUT));
        end
    end

    assign sig = r_sig;

endmodule

`default_nettype wire

// File: rtl/pla_bist_sweeper.sv
// ============================================================================
// Module  : pla_bist_sweeper
// Purpose : Exhaustive input sweep of a combinational PLA with MISR readback.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pla_bist_sweeper
    import pla_bist_pkg::*;
#(
    parameter int unsigned       N_IN          = 8,
    parameter int unsigned       N_OUT         = 8,
    parameter int unsigned       SETTLE_CYCLES = 1,
    parameter logic [N_OUT-1:0]  MISR_POLY     = c_default_poly,
    parameter logic [N_OUT-1:0]  MISR_SEED     = c_default_seed,
    parameter logic [N_OUT-1:0]  EXPECTED_SIG  = 8'h00
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic [N_IN-1:0]  x,
    input  logic [N_OUT-1:0] z,
    output logic             obs_valid,
    input  logic             obs_ready,
    output logic [N_IN-1:0]  obs_vec,
    output logic [N_OUT-1:0] obs_resp,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_OUT-1:0] signature
);

    localparam logic [3:0]    c_settle      = 4'(SETTLE_CYCLES);
    localparam logic [N_IN:0] c_last_vec    = {1'b0, {N_IN{1'b1}}};
    localparam state_t        c_first_state = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_t           r_state;
    logic [N_IN:0]    r_vec;
    logic [3:0]       r_cnt;
    logic [N_IN-1:0]  r_x;
    logic             r_obs_valid;
    logic [N_IN-1:0]  r_obs_vec;
    logic [N_OUT-1:0] r_obs_resp;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    logic             w_start_ok;
    logic             w_load_seed;
    logic             w_misr_en;
    logic [N_OUT-1:0] w_sig;

    assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_load_seed = abort || w_start_ok;
    assign w_misr_en   = (r_state == SAMPLE);

    pla_misr #(
        .N_OUT     (N_OUT),
        .MISR_POLY (MISR_POLY),
        .MISR_SEED (MISR_SEED)
    ) u_misr (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_seed (w_load_seed),
        .enable    (w_misr_en),
        .z         (z),
        .sig       (w_sig)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_vec       <= '0;
            r_cnt       <= '0;
            r_x         <= '0;
            r_obs_valid <= 1'b0;
            r_obs_vec   <= '0;
            r_obs_resp  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else if (abort) begin
            r_state     <= IDLE;
            r_vec       <= '0;
            r_cnt       <= '0;
            r_x         <= '0;
            r_obs_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state <= c_first_state;
                        r_vec   <= '0;
                        r_x     <= '0;
                        r_cnt   <= c_settle;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                    end
                end
                SETTLE: begin
                    // Counter is loaded with SETTLE_CYCLES, so SETTLE lasts exactly that many cycles.
                    if (r_cnt <= 4'd1) begin
                        r_state <= SAMPLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                SAMPLE: begin
                    r_obs_resp  <= z;
                    r_obs_vec   <= r_vec[N_IN-1:0];
                    r_obs_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (r_obs_valid && obs_ready) begin
                        r_obs_valid <= 1'b0;
                        if (r_vec == c_last_vec) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_sig == EXPECTED_SIG);
                        end else begin
                            r_vec   <= r_vec + (N_IN+1)'(1);
                            r_x     <= r_vec[N_IN-1:0] + N_IN'(1);
                            r_cnt   <= c_settle;
                            r_state <= c_first_state;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign x         = r_x;
    assign obs_valid = r_obs_valid;
    assign obs_vec   = r_obs_vec;
    assign obs_resp  = r_obs_resp;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign signature = w_sig;

endmodule

`default_nettype wire
